capcnt_bank: RTL and testbench
==============================

Name: capcnt_bank

Overview:
- Parametrised N-channel tick-counting capture bank with a Wishbone register interface.
- Generalises the fixed per-E1 tick counters captured on USB SOF. Channel count, counter width and capture-source selection are configurable.
- Adds per-channel wrap/overflow flags, a capture sequence number, missed-capture detection and an interrupt.
- Sits on the misc peripheral bus. Used for E1 rx/tx rate measurement against SOF or GPS PPS.

Parameters:
- N_CH, 4, number of tick channels (1..16).
- W, 16, counter/capture width in bits (1..32).
- N_SRC, 2, number of capture source inputs (1..16).

Ports:
- clk  in  1  system clock; all logic is synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  N_CH  per-channel increment strobes, 1-cycle pulses, clk domain.
- cap_src  in  N_SRC  capture event pulses (e.g. SOF, filtered PPS rise), clk domain.
- irq  out  1  registered interrupt, high while capture pending and enabled.
- wb_addr  in  8  word address.
- wb_rdata  out  32  read data.
- wb_wdata  in  32  write data.
- wb_we  in  1  write enable.
- wb_cyc  in  1  cycle strobe.
- wb_ack  out  1  acknowledge.

Behaviour:
- Reset (rst_n low, asynchronous): all counters, captures, flags, CSR fields, cap_seq, irq, wb_ack and wb_rdata go to 0.
- Bus timing:
  - wb_ack <= wb_cyc & ~wb_ack, so the ack is 1 cycle after cyc and never asserted two cycles in a row.
  - wb_rdata is registered. It is 0 whenever cyc is low or ack is high; otherwise it is loaded from the addressed register and is valid in the ack cycle.
  - Writes take effect on the clock edge ending the ack cycle.
  - Unmapped reads return 0. Unmapped writes are ignored.
- Register map (word addresses):
  - 0x00 CSR:
    - [0] en (RW).
    - [7:4] cap_sel (RW).
    - [8] irq_en (RW).
    - [16] cap_valid (RO, write 1 clears).
    - [17] cap_miss (RO sticky, write 1 clears).
    - [31:24] cap_seq (RO).
  - 0x01 OVF: bit ch = sticky wrap flag of channel ch (write 1 clears). Bits N_CH and above read 0.
  - 0x10+ch, ch < N_CH: CAP[ch], zero-extended to 32 bits.
- Counting:
  - en=0: counters held at 0, captures ignored.
  - en=1: cnt[ch] increments by 1 mod 2^W on each tick[ch] cycle.
  - wrap[ch] (internal) sets when cnt goes from 2^W-1 to 0.
- Capture event: cap = en & (cap_sel < N_SRC) & cap_src[cap_sel]. If cap_sel >= N_SRC, no captures occur.
- On cap:
  - CAP[ch] <= cnt[ch] value before this cycle's increment. A tick in the same cycle counts toward the next interval.
  - OVF[ch] |= wrap[ch].
  - wrap[ch] <= (wrap occurring this cycle).
  - cap_seq <= cap_seq+1 mod 256.
  - If cap_valid is already 1, cap_miss <= 1. cap_valid <= 1.
- Simultaneous cap and CSR write-1 to cap_valid: set wins (cap_valid stays 1). The same set-wins rule applies to cap_miss and OVF bits.
- irq <= irq_en & cap_valid, registered, so irq lags cap_valid by 1 cycle.
- Clearing en while a capture is pending leaves CAP, OVF, cap_valid and cap_seq intact. Counters and wrap are zeroed.

Test Plan:
- Reset values: assert rst_n low mid-count, then release. Read 0x00, 0x01 and 0x10 -> all 0, irq=0. Read unmapped 0x05 -> 0; ack exactly 1 cycle after cyc.
- Basic capture: en=1, cap_sel=0, 10 ticks on ch0, then cap_src[0] pulse. CAP0=10, cap_valid=1, cap_seq=1, irq=1 (irq_en=1) one cycle after cap_valid.
- Same-cycle tick+capture: 5 ticks, then tick and cap together, then 1 tick, then cap. CAP0=5, then CAP0=2.
- Wrap: W=4, 17 ticks on ch1, then cap. CAP1=1, OVF bit1=1. Write 0x2 to OVF -> bit1=0. A second cap with no wrap leaves OVF=0.
- Missed capture: two caps with no clear between -> cap_miss=1, cap_seq=2. Write CSR 0x30000 with cap pulse in the ack cycle -> cap_valid stays 1, cap_miss stays 1.
- Source selection: cap_sel=1 -> pulses on cap_src[0] ignored, cap_src[1] captures. cap_sel=5 with N_SRC=2 -> no capture, cap_seq unchanged.

Source files
------------

// File: rtl/capcnt_bank.sv
// capcnt_bank: N-channel tick-counting capture bank with Wishbone CSRs.
// Ports: clk, rst_n, tick[N_CH], cap_src[N_SRC], irq, wb_* slave bus.
module capcnt_bank #(
    parameter int N_CH  = 4,
    parameter int W     = 16,
    parameter int N_SRC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  tick,
    input  logic [N_SRC-1:0] cap_src,
    output logic             irq,
    input  logic [7:0]       wb_addr,
    output logic [31:0]      wb_rdata,
    input  logic [31:0]      wb_wdata,
    input  logic             wb_we,
    input  logic             wb_cyc,
    output logic             wb_ack
);

    localparam logic [W-1:0] CMAX = '1;

    logic [W-1:0]    cnt     [N_CH];
    logic [W-1:0]    cap_reg [N_CH];
    logic [N_CH-1:0] wrap;
    logic [N_CH-1:0] ovf;
    logic [N_CH-1:0] wrap_now;
    logic [N_CH-1:0] ovf_clr;

    logic       en;
    logic [3:0] cap_sel;
    logic       irq_en;
    logic       cap_valid;
    logic       cap_miss;
    logic [7:0] cap_seq;

    logic [15:0] src_ext;
    logic        cap;
    logic        wr;
    logic        wr_csr;
    logic        wr_ovf;
    logic [31:0] rd_val;
    logic        unused_ok;

    // Sources beyond N_SRC read as 0, so cap_sel >= N_SRC never captures.
    always_comb begin
        src_ext = 16'(cap_src);
        cap     = en & src_ext[cap_sel];
        wr      = wb_cyc & wb_ack & wb_we;
        wr_csr  = wr & (wb_addr == 8'h00);
        wr_ovf  = wr & (wb_addr == 8'h01);
        ovf_clr = wr_ovf ? wb_wdata[N_CH-1:0] : '0;
        for (int i = 0; i < N_CH; i++) begin
            wrap_now[i] = tick[i] & (cnt[i] == CMAX);
        end
    end

    assign unused_ok = ^wb_wdata;

    // Counters restart each interval; a tick coinciding with a capture
    // becomes the first count of the new interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i]     <= '0;
                cap_reg[i] <= '0;
            end
            wrap <= '0;
        end else if (!en) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
            wrap <= '0;
        end else if (cap) begin
            for (int i = 0; i < N_CH; i++) begin
                cap_reg[i] <= cnt[i];
                cnt[i]     <= tick[i] ? W'(1) : '0;
            end
            wrap <= wrap_now;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (tick[i]) begin
                    cnt[i] <= cnt[i] + W'(1);
                end
            end
            wrap <= wrap | wrap_now;
        end
    end

    // Status bits: a capture in the same cycle as a write-1 clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en        <= 1'b0;
            cap_sel   <= '0;
            irq_en    <= 1'b0;
            cap_valid <= 1'b0;
            cap_miss  <= 1'b0;
            cap_seq   <= '0;
            ovf       <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr_csr) begin
                en      <= wb_wdata[0];
                cap_sel <= wb_wdata[7:4];
                irq_en  <= wb_wdata[8];
            end
            cap_valid <= (cap_valid & ~(wr_csr & wb_wdata[16])) | cap;
            cap_miss  <= (cap_miss & ~(wr_csr & wb_wdata[17]))
                       | (cap & cap_valid);
            if (cap) begin
                cap_seq <= cap_seq + 8'd1;
            end
            ovf <= (ovf & ~ovf_clr) | (cap ? wrap : '0);
            irq <= irq_en & cap_valid;
        end
    end

    always_comb begin
        rd_val = '0;
        if (wb_addr == 8'h00) begin
            rd_val = {cap_seq, 6'b0, cap_miss, cap_valid,
                      7'b0, irq_en, cap_sel, 3'b0, en};
        end else if (wb_addr == 8'h01) begin
            rd_val = 32'(ovf);
        end
        for (int i = 0; i < N_CH; i++) begin
            if (wb_addr == 8'(16 + i)) begin
                rd_val = 32'(cap_reg[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_rdata <= '0;
        end else begin
            wb_ack   <= wb_cyc & ~wb_ack;
            wb_rdata <= (wb_cyc & ~wb_ack) ? rd_val : '0;
        end
    end

endmodule

// File: tb/tb_capcnt_bank.sv
// tb_capcnt_bank: directed self-checking bench for capcnt_bank.
// Uses N_CH=4, W=4, N_SRC=2 so the wrap case is short.
module tb_capcnt_bank;

    localparam int N_CH  = 4;
    localparam int W     = 4;
    localparam int N_SRC = 2;

    logic             clk;
    logic             rst_n;
    logic [N_CH-1:0]  tick;
    logic [N_SRC-1:0] cap_src;
    logic             irq;
    logic [7:0]       wb_addr;
    logic [31:0]      wb_rdata;
    logic [31:0]      wb_wdata;
    logic             wb_we;
    logic             wb_cyc;
    logic             wb_ack;

    int checks   = 0;
    int failures = 0;

    capcnt_bank #(.N_CH(N_CH), .W(W), .N_SRC(N_SRC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .cap_src  (cap_src),
        .irq      (irq),
        .wb_addr  (wb_addr),
        .wb_rdata (wb_rdata),
        .wb_wdata (wb_wdata),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Holds cyc through the ack cycle; optional capture pulse in that cycle.
    task automatic wb_xfer(input logic [7:0] a, input logic we,
                           input logic [31:0] wd,
                           input logic [N_SRC-1:0] capv,
                           output logic [31:0] rd);
        int lat;
        lat = 0;
        @(negedge clk);
        wb_addr  = a;
        wb_we    = we;
        wb_wdata = wd;
        wb_cyc   = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (wb_ack) begin
                lat = k;
                break;
            end
        end
        chk("ack_latency", 32'(lat), 32'd1);
        rd      = wb_rdata;
        cap_src = capv;
        @(posedge clk);
        #1;
        wb_cyc  = 1'b0;
        wb_we   = 1'b0;
        cap_src = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(a, 1'b0, 32'h0, '0, d);
        chk(tag, d, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(a, 1'b1, d, '0, dummy);
    endtask

    task automatic ticks(input logic [N_CH-1:0] m, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tick = m;
        end
        @(negedge clk);
        tick = '0;
    endtask

    task automatic pulse_cap(input logic [N_SRC-1:0] s,
                             input logic [N_CH-1:0] t);
        @(negedge clk);
        cap_src = s;
        tick    = t;
        @(negedge clk);
        cap_src = '0;
        tick    = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        rst_n    = 1'b0;
        tick     = '0;
        cap_src  = '0;
        wb_addr  = '0;
        wb_wdata = '0;
        wb_we    = 1'b0;
        wb_cyc   = 1'b0;
        #22;
        rst_n = 1'b1;

        // Reset mid-count, released away from a clock edge
        wr(8'h00, 32'h101);
        @(negedge clk);
        tick = 4'b0001;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        tick  = '0;
        #1;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rdata", wb_rdata, 32'd0);
        #10;
        rst_n = 1'b1;
        rd_chk("rst_csr", 8'h00, 32'h0);
        rd_chk("rst_ovf", 8'h01, 32'h0);
        rd_chk("rst_cap0", 8'h10, 32'h0);
        rd_chk("unmapped", 8'h05, 32'h0);
        chk("rst_irq2", 32'(irq), 32'd0);

        // Basic capture, irq lags cap_valid by one cycle
        wr(8'h00, 32'h101);
        ticks(4'b0001, 10);
        pulse_cap(2'b01, 4'b0000);
        chk("irq_lag0", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_lag1", 32'(irq), 32'd1);
        rd_chk("basic_cap0", 8'h10, 32'd10);
        rd_chk("basic_csr", 8'h00, 32'h0101_0101);
        wr(8'h00, 32'h1_0101);
        rd_chk("clr_csr", 8'h00, 32'h0100_0101);
        chk("clr_irq", 32'(irq), 32'd0);

        // Tick coinciding with capture goes to the next interval
        ticks(4'b0001, 5);
        pulse_cap(2'b01, 4'b0001);
        rd_chk("same_cap0a", 8'h10, 32'd5);
        wr(8'h00, 32'h1_0101);
        ticks(4'b0001, 1);
        pulse_cap(2'b01, 4'b0000);
        rd_chk("same_cap0b", 8'h10, 32'd2);
        wr(8'h00, 32'h1_0101);
        rd_chk("same_csr", 8'h00, 32'h0300_0101);

        // Wrap on ch1 with W=4
        ticks(4'b0010, 17);
        pulse_cap(2'b01, 4'b0000);
        rd_chk("wrap_cap1", 8'h11, 32'd1);
        rd_chk("wrap_ovf", 8'h01, 32'h2);
        wr(8'h01, 32'h2);
        rd_chk("ovf_clr", 8'h01, 32'h0);
        pulse_cap(2'b01, 4'b0000);
        rd_chk("nowrap_cap1", 8'h11, 32'd0);
        rd_chk("nowrap_ovf", 8'h01, 32'h0);

        // Missed capture and set-wins against write-1 clear
        rd_chk("miss_csr", 8'h00, 32'h0503_0101);
        wb_xfer(8'h00, 1'b1, 32'h3_0101, 2'b01, d);
        rd_chk("setwins_csr", 8'h00, 32'h0603_0101);
        wr(8'h00, 32'h3_0101);
        rd_chk("miss_clr", 8'h00, 32'h0600_0101);

        // Source selection
        wr(8'h00, 32'h111);
        pulse_cap(2'b01, 4'b0000);
        rd_chk("sel1_ign", 8'h00, 32'h0600_0111);
        ticks(4'b0100, 3);
        pulse_cap(2'b10, 4'b0000);
        rd_chk("sel1_cap2", 8'h12, 32'd3);
        rd_chk("sel1_csr", 8'h00, 32'h0701_0111);
        wr(8'h00, 32'h1_0151);
        pulse_cap(2'b11, 4'b0000);
        rd_chk("sel5_csr", 8'h00, 32'h0700_0151);

        // Disable with capture pending keeps results, zeroes counters
        wr(8'h00, 32'h101);
        ticks(4'b1000, 4);
        pulse_cap(2'b01, 4'b0000);
        wr(8'h00, 32'h0);
        rd_chk("dis_csr", 8'h00, 32'h0801_0000);
        rd_chk("dis_cap3", 8'h13, 32'd4);
        chk("dis_irq", 32'(irq), 32'd0);
        ticks(4'b1000, 3);
        wr(8'h00, 32'h101);
        pulse_cap(2'b01, 4'b0000);
        rd_chk("reen_cap3", 8'h13, 32'd0);
        rd_chk("reen_csr", 8'h00, 32'h0903_0101);
        chk("reen_irq", 32'(irq), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
